// File: rtl/flag_branch_unit_pkg.sv
// Shared encodings for the execute-stage flag/branch logic and the ALU-control decoder.
package flag_branch_unit_pkg;

  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JZ   = 3'b001,
    BR_JN   = 3'b010,
    BR_JC   = 3'b011,
    BR_JMP  = 3'b100
  } br_type_e;

  localparam logic [2:0] UPD_ARITH = 3'b111;
  localparam logic [2:0] UPD_LOGIC = 3'b101;
  localparam logic [2:0] UPD_NONE  = 3'b000;

  // One-hot mask selecting a single flag bit of the 3-bit CCR.
  function automatic logic [2:0] flag_mask(input int idx);
    logic [2:0] m;
    m = 3'b000;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/flag_branch_unit_cond.sv
// Combinational jump condition: taken flag and which CCR bit a taken conditional jump consumes.
module branch_cond
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] flag,
  input  logic [2:0] br_type,
  output logic       cond,
  output logic [2:0] clr_mask
);

  always_comb begin
    cond     = 1'b0;
    clr_mask = 3'b000;
    case (br_type_e'(br_type))
      BR_JZ: begin
        cond     = flag[FLAG_Z];
        clr_mask = flag_mask(FLAG_Z);
      end
      BR_JN: begin
        cond     = flag[FLAG_N];
        clr_mask = flag_mask(FLAG_N);
      end
      BR_JC: begin
        cond     = flag[FLAG_C];
        clr_mask = flag_mask(FLAG_C);
      end
      // Unconditional jumps never consume a flag.
      BR_JMP: cond = 1'b1;
      default: begin
        cond     = 1'b0;
        clr_mask = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Condition-code register, jump resolution, flush generation and one-deep CCR shadow
// for interrupt entry / RTI.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] alu_flag,
  input  logic [FLAG_W-1:0] flag_upd,
  input  logic              setc,
  input  logic              clrc,
  input  logic [2:0]        br_type,
  input  logic [DATA_W-1:0] br_target,
  input  logic              stall,
  input  logic              int_save,
  input  logic              rti_restore,
  output logic [FLAG_W-1:0] flag,
  output logic              br_taken,
  output logic [DATA_W-1:0] pc_redirect,
  output logic              flush,
  output logic              shadow_valid
);

  logic [FLAG_W-1:0] ccr_q;
  logic [FLAG_W-1:0] ccr_d;
  logic [FLAG_W-1:0] shadow_q;
  logic              shadow_valid_q;
  logic              flush_q;
  logic              cond;
  logic [2:0]        clr_mask;
  logic              restore;

  branch_cond u_branch_cond (
    .flag     (ccr_q),
    .br_type  (br_type),
    .cond     (cond),
    .clr_mask (clr_mask)
  );

  assign br_taken    = cond & ~rst & ~stall;
  assign pc_redirect = br_taken ? br_target : '0;

  // A simultaneous int_save takes precedence and suppresses the restore.
  assign restore = rti_restore & shadow_valid_q & ~int_save;

  always_comb begin
    ccr_d = ccr_q;
    for (int i = 0; i < FLAG_W; i++) begin
      if (restore)
        ccr_d[i] = shadow_q[i];
      else if (br_taken && clr_mask[i])
        ccr_d[i] = 1'b0;
      else if ((i == FLAG_C) && clrc)
        ccr_d[i] = 1'b0;
      else if ((i == FLAG_C) && setc)
        ccr_d[i] = 1'b1;
      else if (flag_upd[i])
        ccr_d[i] = alu_flag[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q          <= '0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      flush_q        <= 1'b0;
    end else if (stall) begin
      flush_q <= 1'b0;
    end else begin
      ccr_q   <= ccr_d;
      flush_q <= br_taken;
      if (int_save) begin
        shadow_q       <= ccr_q;
        shadow_valid_q <= 1'b1;
      end else if (restore) begin
        shadow_valid_q <= 1'b0;
      end
    end
  end

  assign flag         = ccr_q;
  assign flush        = flush_q;
  assign shadow_valid = shadow_valid_q;

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Execute-stage consumer of the ALU's 3-bit flag vector {N,C,Z}. It holds the architectural condition-code register (CCR) and applies per-bit updates from ALU ops and SETC/CLRC. It resolves conditional and unconditional jumps against the committed CCR, driving PC redirect and pipeline flush. It also keeps a one-deep shadow copy of the CCR for interrupt entry and RTI.

## Interface
- DATA_W, 16, PC / jump-target width
- FLAG_W, 3, flag vector width; bit 2 = N, bit 1 = C, bit 0 = Z
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- alu_flag  in  FLAG_W  flags produced by the ALU this cycle
- flag_upd  in  FLAG_W  per-bit write enable for alu_flag
  - ADD/SUB = 111
  - AND/OR/NOT = 101
  - LDM/LDD/STD/NOP = 000
- setc  in  1  SETC in EX
- clrc  in  1  CLRC in EX
- br_type  in  3  000 none, 001 JZ, 010 JN, 011 JC, 100 JMP, others = none
- br_target  in  DATA_W  jump target from register file
- stall  in  1  hazard stall; freezes all state
- int_save  in  1  interrupt entry; copy CCR to shadow
- rti_restore  in  1  RTI in EX; copy shadow to CCR
- flag  out  FLAG_W  registered CCR
- br_taken  out  1  combinational, jump resolved taken this cycle
- pc_redirect  out  DATA_W  equals br_target when br_taken, else 0
- flush  out  1  registered; high exactly one cycle after a taken jump
- shadow_valid  out  1  registered; shadow holds an unrestored copy

## Operation
- Condition evaluation uses the current registered `flag`, which holds the result of the instruction that left EX on the previous edge. There is no bypass from `alu_flag`.
  - JZ is taken if Z=1.
  - JN is taken if N=1.
  - JC is taken if C=1.
  - JMP is always taken.
- `br_taken` is forced to 0 whenever `rst` or `stall` is high. A stalled jump is re-evaluated when the stall drops.
- When a conditional jump is taken, its tested flag bit is cleared on the next edge. JMP clears nothing.
- Per-bit next-CCR priority at each edge, highest first:
  1. rst: 000
  2. stall: hold
  3. rti_restore with shadow_valid=1: shadow bit
  4. taken-jump clear: 0
  5. For C only: clrc gives 0, else setc gives 1 (clrc beats setc)
  6. flag_upd[i]=1: alu_flag[i]
  7. Otherwise hold.
- rti_restore with shadow_valid=0 leaves the CCR unchanged and is otherwise ignored.
- Shadow register:
  - int_save (not stalled) loads the shadow with the pre-update CCR and sets shadow_valid.
  - A second int_save while valid overwrites the shadow; no nesting.
  - A restore clears shadow_valid.
  - If int_save and rti_restore arrive together, int_save wins and no restore occurs.
- `flush` is the taken signal registered. It is cleared by rst, and it is also cleared (not held) while stall is high.

## Timing
- Reset values: flag=000, shadow=000, shadow_valid=0, flush=0, br_taken=0, pc_redirect=0.
- Latency:
  - CCR update: 1 cycle. ALU op in cycle n is visible on `flag` and usable by a jump in cycle n+1.
  - Jump resolution: 0 cycles (combinational).
  - flush: 1 cycle after br_taken.
- A jump directly following a flag-setting op sees that op's flags; no hazard cycle is required.
- Reset asserted mid-sequence (shadow valid, jump pending) clears everything on that edge. A jump present in the reset cycle is not taken.
- Stall held for k cycles: state is frozen for k edges and evaluation resumes on the first unstalled cycle.

## Structure
- A shared package holds:
  - FLAG_N/FLAG_C/FLAG_Z bit indices
  - br_type encodings (BR_NONE, BR_JZ, BR_JN, BR_JC, BR_JMP)
  - flag_upd constants (UPD_ARITH=111, UPD_LOGIC=101, UPD_NONE=000)
- Both the ALU-control decoder and this block import the package.
- One natural sub-module: `branch_cond`, combinational (flag, br_type) → taken and clear-mask. The top holds the CCR, shadow and flush registers.

## Test plan
- Reset: hold rst 2 cycles with alu_flag=111, flag_upd=111, br_type=JMP → flag=000, br_taken=0, flush=0, shadow_valid=0.
- Arithmetic then jump: ADD result 0 (alu_flag=011, upd=111) in cycle n; JZ in n+1 → br_taken=1 and pc_redirect=br_target in n+1; flag=010 after n+1 (Z cleared); flush=1 in n+2.
- Logic op preserves C: SETC → flag=010; then OR with alu_flag=101, upd=101 → flag=111; then JC → taken, flag=101.
- Stall: JN with flag=100 and stall=1 for 3 cycles → br_taken=0 and flag holds 100; stall drops → taken, flag becomes 000.
- Interrupt: flag=110, int_save → shadow_valid=1; ADD sets flag=001; rti_restore → flag=110, shadow_valid=0; a second rti_restore → flag unchanged.
- Simultaneous events:
  - setc+clrc together → C=0.
  - int_save+rti_restore together with shadow valid → shadow reloaded with current CCR, CCR not restored, shadow_valid stays 1.
